// File: rtl/jamma_joy_serial_if.sv
// Pin-side and core-side signals of the JAMMA joystick chain reader.
// master: the chain reader itself; slave: whoever drives ce/joy_data and consumes the words.
interface jamma_joy_serial_if;
    logic        ce;
    logic        joy_data;
    logic        joy_clk;
    logic        joy_load;
    logic [11:0] joystick1;
    logic [11:0] joystick2;
    logic        frame_done;
    logic        changed;

    modport master (
        input  ce,
        input  joy_data,
        output joy_clk,
        output joy_load,
        output joystick1,
        output joystick2,
        output frame_done,
        output changed
    );

    modport slave (
        output ce,
        output joy_data,
        input  joy_clk,
        input  joy_load,
        input  joystick1,
        input  joystick2,
        input  frame_done,
        input  changed
    );
endinterface

// File: rtl/jamma_joy_serial.sv
// Scans the JAMMA adapter shift-register chain and deserialises two active-low
// 12-bit player words, only passing a new value on after DEBOUNCE identical frames.
module jamma_joy_serial #(
    parameter int unsigned FRAME_LEN = 26,
    parameter int unsigned DEBOUNCE  = 2
) (
    input logic                clk,
    input logic                reset,
    jamma_joy_serial_if.master joy
);
    localparam int unsigned      SlotW     = $clog2(FRAME_LEN);
    localparam logic [SlotW-1:0] LastSlot  = SlotW'(FRAME_LEN - 1);
    localparam logic [2:0]       StableMax = 3'(DEBOUNCE);
    // Data slot k (= slot - 2): target bit, and whether it belongs to player 2.
    localparam logic [3:0] BitMap [24] = '{
        4'd8, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0,
        4'd8, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0,
        4'd10, 4'd11, 4'd9, 4'd7,
        4'd10, 4'd11, 4'd9, 4'd7
    };
    localparam logic [23:0] PlayerTwo = 24'h0FFF00;

    logic             data_meta, data_sync;
    logic             joy_clk_q, joy_clk_d;
    logic             joy_load_q, joy_load_d;
    logic [SlotW-1:0] slot_q, slot_d;
    logic [11:0]      j1_work_q, j1_work_d, j2_work_q, j2_work_d;
    logic [11:0]      j1_cap, j2_cap;
    logic [23:0]      shadow_q, shadow_d;
    logic [23:0]      out_q, out_d;
    logic [2:0]       stable_q, stable_d;
    logic             frame_done_q, frame_done_d;
    logic             changed_q, changed_d;
    logic             rise, frame_end, map_hit;
    logic [4:0]       map_idx;

    always_comb begin
        rise      = joy.ce & ~joy_clk_q;
        joy_clk_d = joy_clk_q ^ joy.ce;
        frame_end = rise && (slot_q == LastSlot);

        slot_d = slot_q;
        if (rise) begin
            slot_d = frame_end ? '0 : slot_q + 1'b1;
        end
        joy_load_d = rise ? (slot_d != '0) : joy_load_q;

        // Sampling is keyed on the slot being left, not the one being entered.
        map_idx = 5'(int'(slot_q) - 2);
        map_hit = rise && (int'(slot_q) >= 2) && (int'(slot_q) <= 25);
        j1_cap  = j1_work_q;
        j2_cap  = j2_work_q;
        if (map_hit) begin
            if (PlayerTwo[map_idx]) begin
                j2_cap[BitMap[map_idx]] = data_sync;
            end else begin
                j1_cap[BitMap[map_idx]] = data_sync;
            end
        end

        j1_work_d    = j1_cap;
        j2_work_d    = j2_cap;
        shadow_d     = shadow_q;
        stable_d     = stable_q;
        out_d        = out_q;
        frame_done_d = 1'b0;
        changed_d    = 1'b0;

        if (frame_end) begin
            // Fresh working words each frame so unmapped bits read as released.
            j1_work_d    = 12'hFFF;
            j2_work_d    = 12'hFFF;
            frame_done_d = 1'b1;
            if ({j1_cap, j2_cap} == shadow_q) begin
                if (stable_q != StableMax) begin
                    stable_d = stable_q + 1'b1;
                end
            end else begin
                shadow_d = {j1_cap, j2_cap};
                stable_d = 3'd1;
            end
            if ((stable_d == StableMax) && (shadow_d != out_q)) begin
                out_d     = shadow_d;
                changed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_meta    <= 1'b1;
            data_sync    <= 1'b1;
            joy_clk_q    <= 1'b0;
            joy_load_q   <= 1'b1;
            slot_q       <= '0;
            j1_work_q    <= 12'hFFF;
            j2_work_q    <= 12'hFFF;
            shadow_q     <= 24'hFFFFFF;
            out_q        <= 24'hFFFFFF;
            stable_q     <= 3'd0;
            frame_done_q <= 1'b0;
            changed_q    <= 1'b0;
        end else begin
            data_meta    <= joy.joy_data;
            data_sync    <= data_meta;
            joy_clk_q    <= joy_clk_d;
            joy_load_q   <= joy_load_d;
            slot_q       <= slot_d;
            j1_work_q    <= j1_work_d;
            j2_work_q    <= j2_work_d;
            shadow_q     <= shadow_d;
            out_q        <= out_d;
            stable_q     <= stable_d;
            frame_done_q <= frame_done_d;
            changed_q    <= changed_d;
        end
    end

    assign joy.joy_clk    = joy_clk_q;
    assign joy.joy_load   = joy_load_q;
    assign joy.joystick1  = out_q[23:12];
    assign joy.joystick2  = out_q[11:0];
    assign joy.frame_done = frame_done_q;
    assign joy.changed    = changed_q;
endmodule

// File: tb/tb_jamma_joy_serial.sv
// Directed bench: a behavioural chain drives two readers (DEBOUNCE=2 and DEBOUNCE=1) in
// lockstep; expected words are queued when patterns are driven and popped on each changed pulse.
module tb_jamma_joy_serial;
    typedef struct packed {
        logic [11:0] j1;
        logic [11:0] j2;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ce = 1'b0;
    logic ce_en = 1'b0;
    logic joy_data = 1'b1;

    jamma_joy_serial_if ifa ();
    jamma_joy_serial_if ifb ();

    assign ifa.ce       = ce;
    assign ifb.ce       = ce;
    assign ifa.joy_data = joy_data;
    assign ifb.joy_data = joy_data;

    jamma_joy_serial #(.FRAME_LEN(26), .DEBOUNCE(2)) dut_a (
        .clk  (clk),
        .reset(reset),
        .joy  (ifa.master)
    );

    jamma_joy_serial #(.FRAME_LEN(26), .DEBOUNCE(1)) dut_b (
        .clk  (clk),
        .reset(reset),
        .joy  (ifb.master)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    int unsigned map_bit[24] = '{8, 6, 5, 4, 3, 2, 1, 0, 8, 6, 5, 4, 3, 2, 1, 0,
                                 10, 11, 9, 7, 10, 11, 9, 7};

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] serialize(input logic [11:0] w1, input logic [11:0] w2);
        logic [23:0] b;
        for (int k = 0; k < 24; k++) begin
            b[k] = (k >= 8 && k <= 19) ? w2[map_bit[k]] : w1[map_bit[k]];
        end
        return b;
    endfunction

    function automatic exp_t deserialize(input logic [23:0] b);
        exp_t e;
        e.j1 = 12'hFFF;
        e.j2 = 12'hFFF;
        for (int k = 0; k < 24; k++) begin
            if (k >= 8 && k <= 19) e.j2[map_bit[k]] = b[k];
            else                   e.j1[map_bit[k]] = b[k];
        end
        return e;
    endfunction

    // ce at half clock rate whenever enabled.
    initial forever begin
        @(negedge clk);
        ce = ce_en ? ~ce : 1'b0;
    end

    // Chain model: tracks the slot from the pins and presents the bit for the current slot.
    logic [23:0] cur_bits = '1;
    int          model_slot = 0;
    logic        prev_jc = 1'b0;
    initial forever begin
        @(negedge clk);
        if (reset) begin
            model_slot = 0;
            prev_jc    = 1'b0;
            joy_data   = 1'b1;
        end else begin
            if (ifa.joy_clk && !prev_jc) model_slot = (model_slot == 25) ? 0 : model_slot + 1;
            if (!ifa.joy_load) model_slot = 0;
            prev_jc  = ifa.joy_clk;
            joy_data = (model_slot >= 2) ? cur_bits[model_slot-2] : 1'b1;
        end
    end

    int ce_cnt = 0;
    int low_cnt = 0;
    always @(posedge clk) begin
        if (reset) begin
            ce_cnt  <= 0;
            low_cnt <= 0;
        end else if (ce) begin
            ce_cnt <= ce_cnt + 1;
            if (!ifa.joy_load) low_cnt <= low_cnt + 1;
        end
    end

    int frame_idx = 0;
    int last_ce = 0;
    int last_low = 0;
    always @(negedge clk) begin
        if (reset) begin
            frame_idx = 0;
            last_ce   = 0;
            last_low  = 0;
        end else begin
            if (ifa.frame_done) begin
                frame_idx++;
                if (frame_idx == 1) check("first_frame_ce", 24'(ce_cnt), 24'd51);
                else                check("frame_ce", 24'(ce_cnt - last_ce), 24'd52);
                if (frame_idx >= 2) check("load_low_ce", 24'(low_cnt - last_low), 24'd2);
                last_ce  = ce_cnt;
                last_low = low_cnt;
            end
            if (ifa.changed) begin
                if (q_a.size() == 0) check("a_unexpected_change", 24'(ifa.changed), 24'd0);
                else check("a_words", {ifa.joystick1, ifa.joystick2}, q_a.pop_front());
            end
            if (ifb.changed) begin
                if (q_b.size() == 0) check("b_unexpected_change", 24'(ifb.changed), 24'd0);
                else check("b_words", {ifb.joystick1, ifb.joystick2}, q_b.pop_front());
            end
        end
    end

    task automatic wait_frames(input int n);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!ifa.frame_done && t < 400);
            check("frame_done_seen", 24'(ifa.frame_done), 24'd1);
        end
        #1;
    endtask

    task automatic wait_slot(input int s);
        int t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while (model_slot != s && t < 300);
        check("slot_reached", 24'(model_slot), 24'(s));
    endtask

    task automatic set_pattern(input logic [11:0] w1, input logic [11:0] w2,
                               input bit push_a, input bit push_b);
        exp_t e;
        e.j1 = w1;
        e.j2 = w2;
        cur_bits = serialize(w1, w2);
        if (push_a) q_a.push_back(e);
        if (push_b) q_b.push_back(e);
    endtask

    initial begin
        exp_t e;
        int   fi;
        repeat (3) @(negedge clk);
        #1;
        check("rst_a_j1", 24'(ifa.joystick1), 24'hFFF);
        check("rst_a_j2", 24'(ifa.joystick2), 24'hFFF);
        check("rst_b_j1", 24'(ifb.joystick1), 24'hFFF);
        check("rst_load", 24'(ifa.joy_load), 24'd1);
        check("rst_jclk", 24'(ifa.joy_clk), 24'd0);
        check("rst_fdone", 24'(ifa.frame_done), 24'd0);
        check("rst_changed", 24'(ifa.changed), 24'd0);
        @(negedge clk);
        reset  = 1'b0;
        ce_en  = 1'b1;
        wait_frames(2);

        // Two identical frames of a pressed button.
        set_pattern(12'hFFE, 12'h7FF, 1'b1, 1'b1);
        wait_frames(1);
        check("t2_a_held", 24'(ifa.joystick1), 24'hFFF);
        check("t2_b_j1", 24'(ifb.joystick1), 24'hFFE);
        wait_frames(1);
        check("t2_a_j1", 24'(ifa.joystick1), 24'hFFE);
        check("t2_a_j2", 24'(ifa.joystick2), 24'h7FF);
        check("t2_a_queue", 24'(q_a.size()), 24'd0);

        // Back to idle, then a one-frame glitch on j1[4].
        set_pattern(12'hFFF, 12'hFFF, 1'b1, 1'b1);
        wait_frames(2);
        set_pattern(12'hFEF, 12'hFFF, 1'b0, 1'b1);
        wait_frames(1);
        check("t3_b_glitch", 24'(ifb.joystick1), 24'hFEF);
        set_pattern(12'hFFF, 12'hFFF, 1'b0, 1'b1);
        wait_frames(2);
        check("t3_a_j1", 24'(ifa.joystick1), 24'hFFF);

        // ce gap mid-frame.
        set_pattern(12'h5A3, 12'hC3C, 1'b1, 1'b1);
        wait_slot(13);
        fi    = frame_idx;
        ce_en = 1'b0;
        repeat (102) @(negedge clk);
        #1;
        check("t6_no_frame", 24'(frame_idx), 24'(fi));
        check("t6_load", 24'(ifa.joy_load), 24'd1);
        check("t6_a_j1", 24'(ifa.joystick1), 24'hFFF);
        check("t6_b_j2", 24'(ifb.joystick2), 24'hFFF);
        ce_en = 1'b1;
        wait_frames(1);
        check("t6_b_words", {ifb.joystick1, ifb.joystick2}, 24'h5A3C3C);
        wait_frames(1);
        check("t6_a_words", {ifa.joystick1, ifa.joystick2}, 24'h5A3C3C);

        // Reset in the middle of an all-pressed frame.
        set_pattern(12'h000, 12'h000, 1'b0, 1'b0);
        wait_slot(13);
        reset = 1'b1;
        #1;
        check("t1_a_j1", 24'(ifa.joystick1), 24'hFFF);
        check("t1_a_j2", 24'(ifa.joystick2), 24'hFFF);
        check("t1_load", 24'(ifa.joy_load), 24'd1);
        check("t1_jclk", 24'(ifa.joy_clk), 24'd0);
        cur_bits = '1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        wait_frames(2);
        check("t1_a_after", {ifa.joystick1, ifa.joystick2}, 24'hFFFFFF);
        check("t1_b_after", {ifb.joystick1, ifb.joystick2}, 24'hFFFFFF);

        // Walking zero through every data slot; DEBOUNCE=1 follows each frame.
        for (int k = 0; k < 24; k++) begin
            logic [23:0] bits;
            bits     = '1;
            bits[k]  = 1'b0;
            cur_bits = bits;
            e        = deserialize(bits);
            q_b.push_back(e);
            wait_frames(1);
            check("t5_b_words", {ifb.joystick1, ifb.joystick2}, e);
            if (k == 17) check("t5_slot19_j2_11", 24'(ifb.joystick2[11]), 24'd0);
            if (k == 0)  check("t5_slot2_j1_8", 24'(ifb.joystick1), 24'hEFF);
            if (k == 20) check("t5_slot22_j1_10", 24'(ifb.joystick1), 24'hBFF);
        end
        check("t5_a_held", {ifa.joystick1, ifa.joystick2}, 24'hFFFFFF);
        set_pattern(12'hFFF, 12'hFFF, 1'b0, 1'b1);
        wait_frames(2);
        check("end_a_queue", 24'(q_a.size()), 24'd0);
        check("end_b_queue", 24'(q_b.size()), 24'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
